// File: rtl/iecdrv_gcr_stream.sv
// Head model on the track bit memory port B: steps the bit address at the zone bit rate,
// assembles GCR bytes and SYNC in read mode; the write path exists only with IECDRV_GCR_WRITE_EN.
module iecdrv_gcr_stream #(
    parameter int ADDRWIDTH = 13
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ce,
    input  logic                 mtr,
    input  logic                 busy,
    input  logic                 mode,
    input  logic [1:0]           freq,
    input  logic [ADDRWIDTH+2:0] track_len,
    input  logic [7:0]           din,
    output logic [ADDRWIDTH+2:0] bit_addr,
    input  logic                 bit_in,
    output logic                 bit_out,
    output logic                 bit_we,
    output logic [7:0]           dout,
    output logic                 byte_ready,
    output logic                 sync_n
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t               state;
    logic [5:0]           div;
    logic [5:0]           div_last;
    logic [1:0]           freq_q;
    logic [2:0]           bit_cnt;
    logic [9:0]           rshift;
    logic [9:0]           rshift_nxt;
    logic                 mode_q;
    logic                 mode_eff;
    logic                 go;
    logic [ADDRWIDTH+3:0] addr_inc;
    logic [ADDRWIDTH+2:0] addr_nxt;

`ifdef IECDRV_GCR_WRITE_EN
    logic [7:0] wshift;
    logic       we_q;
    logic       out_q;

    assign mode_eff = mode;
    assign bit_we   = we_q;
    assign bit_out  = out_q;
`else
    logic unused_write;

    assign mode_eff     = 1'b1;
    assign bit_we       = 1'b0;
    assign bit_out      = 1'b0;
    assign unused_write = &{1'b0, mode, din};
`endif

    // Period is 4*(16-freq) ticks, so the last divider value is 63 - 4*freq.
    assign div_last   = 6'd63 - {2'b00, freq_q, 2'b00};
    assign go         = mtr & ~busy & (track_len != '0);
    assign rshift_nxt = {rshift[8:0], bit_in};
    // One extra bit so the compare also catches a track that shrank below the head.
    assign addr_inc   = {1'b0, bit_addr} + (ADDRWIDTH + 4)'(1);
    assign addr_nxt   = (addr_inc >= {1'b0, track_len}) ? '0 : addr_inc[ADDRWIDTH+2:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            div        <= '0;
            freq_q     <= '0;
            bit_addr   <= '0;
            bit_cnt    <= '0;
            rshift     <= '0;
            mode_q     <= 1'b1;
            dout       <= '0;
            byte_ready <= 1'b0;
            sync_n     <= 1'b1;
`ifdef IECDRV_GCR_WRITE_EN
            wshift     <= '0;
            we_q       <= 1'b0;
            out_q      <= 1'b0;
`endif
        end else begin
`ifdef IECDRV_GCR_WRITE_EN
            we_q <= 1'b0;
`endif
            if (ce) begin
                byte_ready <= 1'b0;
                case (state)
                    IDLE: begin
                        div    <= '0;
                        freq_q <= freq;
                        if (go) begin
                            state <= RUN;
                        end
                    end
                    RUN: begin
                        if (!go) begin
                            state <= IDLE;
                            div   <= '0;
                        end else begin
                            if (div == div_last) begin
                                div      <= '0;
                                freq_q   <= freq;
                                bit_addr <= addr_nxt;
                                // A mode switch drops the bit in flight and restarts the byte.
                                if (mode_eff != mode_q) begin
                                    mode_q  <= mode_eff;
                                    bit_cnt <= '0;
                                    sync_n  <= 1'b1;
                                end
`ifdef IECDRV_GCR_WRITE_EN
                                else if (!mode_q) begin
                                    wshift  <= {wshift[6:0], 1'b0};
                                    bit_cnt <= bit_cnt + 3'd1;
                                    if (bit_cnt == 3'd7) begin
                                        wshift     <= din;
                                        byte_ready <= 1'b1;
                                    end
                                end
`endif
                            end else begin
                                div <= div + 6'd1;
                            end

                            // Memory data is two clocks behind the address; sample on tick 3.
                            if (mode_q && div == 6'd2) begin
                                rshift <= rshift_nxt;
                                if (rshift_nxt == 10'h3FF) begin
                                    sync_n  <= 1'b0;
                                    bit_cnt <= '0;
                                end else begin
                                    sync_n  <= 1'b1;
                                    bit_cnt <= bit_cnt + 3'd1;
                                    if (bit_cnt == 3'd7) begin
                                        dout       <= rshift_nxt[7:0];
                                        byte_ready <= 1'b1;
                                    end
                                end
                            end
`ifdef IECDRV_GCR_WRITE_EN
                            if (!mode_q && div == '0) begin
                                we_q  <= 1'b1;
                                out_q <= wshift[7];
                            end
`endif
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
